// File: rtl/aging_meas_sched.sv
// aging_meas_sched
//   Sequencer for the aging-sensor measurement loop. Each accepted start
//   sweeps NUM_SENSORS ring-oscillator counters: clear, count window,
//   capture, then stream the 16-bit count to the UART TX (high byte first)
//   over a valid/ready handshake.
//
// Optional build macro:
//   AGING_HDR_EN - prepend a header byte {4'hA, idx[3:0]} to each channel.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   start       one-cycle sweep request (ignored unless idle)
//   sens_count  count of the selected sensor, sampled in CAPTURE
//   sens_sel    index of the sensor being measured
//   sens_clr    one-cycle clear to the selected sensor counter
//   sens_en     count-window enable
//   tx_data     byte to the UART
//   tx_valid    tx_data is valid
//   tx_ready    UART accepts the byte (transfer on tx_valid && tx_ready)
//   busy        sweep in progress
//   done        one-cycle pulse at the end of the sweep
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for a registered start request
// CLEAR    | one-cycle clear pulse to sensor idx
// WINDOW   | count window, WIN_CYC cycles (win_cnt 0..WIN_CYC-1)
// CAPTURE  | sample sens_count into cap
// SEND_HDR | header byte {4'hA, idx} (AGING_HDR_EN only)
// SEND_HI  | cap[15:8] on the UART
// SEND_LO  | cap[7:0] on the UART
// NEXT     | advance idx or finish the sweep (done pulse)

module aging_meas_sched #(
  parameter int NUM_SENSORS = 4,
  parameter int SEL_W       = 4,
  parameter int WIN_CYC     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      sens_count,
  output logic [SEL_W-1:0] sens_sel,
  output logic             sens_clr,
  output logic             sens_en,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    WINDOW   = 3'd2,
    CAPTURE  = 3'd3,
    SEND_HI  = 3'd4,
    SEND_LO  = 3'd5,
    NEXT     = 3'd6
`ifdef AGING_HDR_EN
    , SEND_HDR = 3'd7
`endif
  } state_t;

  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_SENSORS - 1);
  localparam logic [15:0]      WIN_LAST = 16'(WIN_CYC - 1);

  state_t           state, state_nx;
  logic [SEL_W-1:0] idx, idx_nx;
  logic [15:0]      win_cnt, win_cnt_nx;
  logic [15:0]      cap, cap_d;
  logic             start_q, start_q_nx;
  logic             last_nx;

  logic [SEL_W-1:0] sens_sel_nx;
  logic             sens_clr_nx, sens_en_nx;
  logic [7:0]       tx_data_nx;
  logic             tx_valid_nx, busy_nx, done_nx;

  // Start is registered before the FSM sees it. Requests are only taken
  // while idle and not already pending, which also drops a start that
  // coincides with the done cycle (state is NEXT then).
  assign start_q_nx = start && (state == IDLE) && !start_q;

  // The capture register loads on the CAPTURE edge, which is the same edge
  // that loads the first tx_data byte, so look through to sens_count there.
  assign cap_d = (state == CAPTURE) ? sens_count : cap;

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    win_cnt_nx = win_cnt;
    case (state)
      IDLE: begin
        if (start_q) begin
          state_nx = CLEAR;
          idx_nx   = '0;
        end
      end
      CLEAR: begin
        state_nx   = WINDOW;
        win_cnt_nx = '0;
      end
      WINDOW: begin
        if (win_cnt == WIN_LAST) state_nx = CAPTURE;
        else                     win_cnt_nx = win_cnt + 16'd1;
      end
      CAPTURE: begin
`ifdef AGING_HDR_EN
        state_nx = SEND_HDR;
`else
        state_nx = SEND_HI;
`endif
      end
`ifdef AGING_HDR_EN
      SEND_HDR: begin
        if (tx_valid && tx_ready) state_nx = SEND_HI;
      end
`endif
      SEND_HI: begin
        if (tx_valid && tx_ready) state_nx = SEND_LO;
      end
      SEND_LO: begin
        if (tx_valid && tx_ready) state_nx = NEXT;
      end
      NEXT: begin
        if (idx == IDX_LAST) begin
          state_nx = IDLE;
        end else begin
          state_nx = CLEAR;
          idx_nx   = idx + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state register; the handshake can then advance on the accepting edge.
  always_comb begin
    last_nx     = (state_nx == NEXT) && (idx_nx == IDX_LAST);
    sens_sel_nx = (state_nx == IDLE) ? '0 : idx_nx;
    sens_clr_nx = (state_nx == CLEAR);
    sens_en_nx  = (state_nx == WINDOW);
    busy_nx     = (state_nx != IDLE) && !last_nx;
    done_nx     = last_nx;
    tx_valid_nx = 1'b0;
    tx_data_nx  = 8'h00;
    case (state_nx)
`ifdef AGING_HDR_EN
      SEND_HDR: begin
        tx_valid_nx = 1'b1;
        tx_data_nx  = {4'hA, 4'(idx_nx)};
      end
`endif
      SEND_HI: begin
        tx_valid_nx = 1'b1;
        tx_data_nx  = cap_d[15:8];
      end
      SEND_LO: begin
        tx_valid_nx = 1'b1;
        tx_data_nx  = cap_d[7:0];
      end
      default: begin
        tx_valid_nx = 1'b0;
        tx_data_nx  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      win_cnt <= '0;
      cap     <= '0;
      start_q <= 1'b0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      win_cnt <= win_cnt_nx;
      cap     <= cap_d;
      start_q <= start_q_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sens_sel <= '0;
      sens_clr <= 1'b0;
      sens_en  <= 1'b0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      sens_sel <= sens_sel_nx;
      sens_clr <= sens_clr_nx;
      sens_en  <= sens_en_nx;
      tx_data  <= tx_data_nx;
      tx_valid <= tx_valid_nx;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end

endmodule

// File: tb/tb_aging_meas_sched.sv
`timescale 1ns/1ps
// Directed bench for aging_meas_sched (NUM_SENSORS=4, WIN_CYC=16).
module tb_aging_meas_sched;

  localparam int NS  = 4;
  localparam int SW  = 4;
  localparam int WIN = 16;
`ifdef AGING_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [15:0]   sens_count;
  logic [SW-1:0] sens_sel;
  logic          sens_clr, sens_en;
  logic [7:0]    tx_data;
  logic          tx_valid, tx_ready;
  logic          busy, done;

  logic [15:0]   cnt_base;
  logic          cnt_add_idx;
  logic          stall_mode;

  assign sens_count = cnt_add_idx ? cnt_base + 16'(sens_sel) : cnt_base;

  always #5 clk = ~clk;

  aging_meas_sched #(.NUM_SENSORS(NS), .SEL_W(SW), .WIN_CYC(WIN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sens_count(sens_count),
    .sens_sel(sens_sel), .sens_clr(sens_clr), .sens_en(sens_en),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         en_runs[$];
  int         run_len, clr_cnt, done_cnt;
  logic       p_valid, p_ready;
  logic [7:0] p_data;

  initial begin
    p_valid = 0; p_ready = 0; p_data = 0;
    run_len = 0; clr_cnt = 0; done_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_valid = 0;
        p_ready = 0;
      end else begin
        if (p_valid && !p_ready) begin
          chk("hold_valid", {31'd0, tx_valid}, 32'd1);
          chk("hold_data", {24'd0, tx_data}, {24'd0, p_data});
        end
        if (tx_valid && tx_ready) rx_q.push_back(tx_data);
        if (sens_en) run_len++;
        else if (run_len != 0) begin
          en_runs.push_back(run_len);
          run_len = 0;
        end
        if (sens_clr) clr_cnt++;
        if (done) done_cnt++;
        p_valid = tx_valid;
        p_ready = tx_ready;
        p_data  = tx_data;
      end
    end
  end

  // ---------------- tx_ready driver ----------------
  // stall_mode: each byte sees tx_ready low for 5 cycles, then high for 1.
  int stall;
  initial begin
    tx_ready = 0;
    stall = 0;
    forever begin
      @(posedge clk); #1;
      if (!stall_mode)    tx_ready = 1;
      else if (!tx_valid) begin tx_ready = 0; stall = 0; end
      else if (tx_ready)  begin tx_ready = 0; stall = 1; end
      else if (stall >= 5) tx_ready = 1;
      else stall++;
    end
  end

  // ---------------- helpers ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(input int budget, output int edges);
    edges = 0;
    while (!done && edges < budget) begin
      @(posedge clk); #1;
      edges++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_mon();
    rx_q.delete();
    en_runs.delete();
    run_len = 0; clr_cnt = 0; done_cnt = 0;
  endtask

  task automatic build_exp(input logic [15:0] base, input logic add);
    logic [15:0] v;
    exp_q.delete();
    for (int ch = 0; ch < NS; ch++) begin
      v = add ? base + 16'(ch) : base;
      if (HDR != 0) exp_q.push_back({4'hA, 4'(ch)});
      exp_q.push_back(v[15:8]);
      exp_q.push_back(v[7:0]);
    end
  endtask

  task automatic check_bytes(input string tag);
    chk({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
  endtask

  task automatic check_idle(input string tag);
    chk(tag, {15'd0, sens_sel, sens_clr, sens_en, tx_data, tx_valid, busy, done}, 32'd0);
  endtask

  // ---------------- main ----------------
  int e;
  int n;

  initial begin
    rst_n = 0; start = 0; stall_mode = 0;
    cnt_base = 16'h0000; cnt_add_idx = 0;
    step(3);
    rst_n = 1;

    // idle with no start, tx_ready high throughout
    for (int i = 0; i < 100; i++) begin
      step(1);
      check_idle("idle_outs");
    end

    // full sweep, tx_ready tied high, counts 0x1234+idx
    clear_mon();
    cnt_base = 16'h1234; cnt_add_idx = 1;
    pulse_start();
    chk("busy_after_start", {31'd0, busy}, 32'd0);
    chk("clr_after_start", {31'd0, sens_clr}, 32'd0);
    step(1);
    chk("clr_lat", {31'd0, sens_clr}, 32'd1);
    chk("busy_lat", {31'd0, busy}, 32'd1);
    chk("sel_first", {28'd0, sens_sel}, 32'd0);
    wait_done(2000, e);
    chk("sweep_len", e + 1, NS * (WIN + 5 + HDR));
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    step(1);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("sel_back_0", {28'd0, sens_sel}, 32'd0);
    step(5);
    build_exp(16'h1234, 1'b1);
    check_bytes("seq");
    chk("en_runs", en_runs.size(), NS);
    for (int i = 0; i < en_runs.size(); i++) chk("en_len", en_runs[i], WIN);
    chk("done_cnt", done_cnt, 1);
    chk("clr_cnt", clr_cnt, NS);

    // stalled handshake plus start mid-sweep and in the done cycle
    clear_mon();
    stall_mode = 1;
    pulse_start();
    step(30);
    chk("busy_mid", {31'd0, busy}, 32'd1);
    pulse_start();
    wait_done(3000, e);
    start = 1;
    step(1);
    start = 0;
    step(60);
    chk("no_restart", {31'd0, busy}, 32'd0);
    build_exp(16'h1234, 1'b1);
    check_bytes("stall");
    chk("stall_clr_cnt", clr_cnt, NS);
    chk("stall_done_cnt", done_cnt, 1);

    // reset while a stalled byte is pending
    pulse_start();
    n = 0;
    while (!tx_valid && n < 500) begin step(1); n++; end
    chk("find_send", {31'd0, tx_valid}, 32'd1);
    step(2);
    rst_n = 0;
    #1;
    chk("rst_txv", {31'd0, tx_valid}, 32'd0);
    chk("rst_txd", {24'd0, tx_data}, 32'd0);
    step(1);
    rst_n = 1;
    stall_mode = 0;
    step(3);
    check_idle("idle_after_rst1");

    // reset during channel 2 window, then a fresh sweep
    clear_mon();
    pulse_start();
    n = 0;
    while (!(sens_en && sens_sel == 4'd2) && n < 500) begin step(1); n++; end
    chk("find_win2", {31'd0, sens_en && sens_sel == 4'd2}, 32'd1);
    step(3);
    rst_n = 0;
    #1;
    chk("rst_en", {31'd0, sens_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sel", {28'd0, sens_sel}, 32'd0);
    step(1);
    rst_n = 1;
    step(10);
    check_idle("idle_after_rst2");
    clear_mon();
    pulse_start();
    step(1);
    chk("fresh_clr", {31'd0, sens_clr}, 32'd1);
    chk("fresh_sel", {28'd0, sens_sel}, 32'd0);
    wait_done(2000, e);
    step(3);
    build_exp(16'h1234, 1'b1);
    check_bytes("fresh");

    // all-ones count passes through unchanged
    clear_mon();
    cnt_base = 16'hFFFF; cnt_add_idx = 0;
    pulse_start();
    wait_done(2000, e);
    step(3);
    build_exp(16'hFFFF, 1'b0);
    check_bytes("ffff");

    // 0xBEEF on every channel (headers present when built with AGING_HDR_EN)
    clear_mon();
    cnt_base = 16'hBEEF;
    pulse_start();
    wait_done(2000, e);
    step(3);
    build_exp(16'hBEEF, 1'b0);
    check_bytes("beef");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
